// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline stage register: 2-entry skid buffer between fetch and decode
// with flush, decode stall, NOP insertion while empty and a saturating stall counter.
module if_id_stage_reg #(
    parameter int              XLEN  = 32,
    parameter int              ILEN  = 32,
    parameter logic [ILEN-1:0] NOP   = 32'h0000_0013,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    input  logic             in_pred_taken,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic             out_pred_taken,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   head_pc_reg;
    logic [ILEN-1:0]   head_instr_reg;
    logic              head_pred_reg;
    logic [XLEN-1:0]   skid_pc_reg;
    logic [ILEN-1:0]   skid_instr_reg;
    logic              skid_pred_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic push;
    logic pop;

    // Handshake signals depend only on the state register, never on decode-side inputs.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign occupancy = state_reg;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & ~stall;

    assign out_pc         = head_pc_reg;
    assign out_instr      = out_valid ? head_instr_reg : NOP;
    assign out_pred_taken = out_valid & head_pred_reg;
    assign stall_cnt      = stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= EMPTY;
            head_pc_reg    <= '0;
            head_instr_reg <= NOP;
            head_pred_reg  <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= NOP;
            skid_pred_reg  <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            if (out_valid && !pop && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            // Flush drops everything, including a push arriving in the same cycle.
            if (flush) begin
                state_reg <= EMPTY;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (push) begin
                            head_pc_reg    <= in_pc;
                            head_instr_reg <= in_instr;
                            head_pred_reg  <= in_pred_taken;
                            state_reg      <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_pc_reg    <= in_pc;
                            head_instr_reg <= in_instr;
                            head_pred_reg  <= in_pred_taken;
                        end else if (push) begin
                            skid_pc_reg    <= in_pc;
                            skid_instr_reg <= in_instr;
                            skid_pred_reg  <= in_pred_taken;
                            state_reg      <= FULL;
                        end else if (pop) begin
                            state_reg <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head_pc_reg    <= skid_pc_reg;
                            head_instr_reg <= skid_instr_reg;
                            head_pred_reg  <= skid_pred_reg;
                            state_reg      <= ONE;
                        end
                    end
                    default: state_reg <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed scenarios plus random traffic checked
// against a queue-based reference model of the buffer.
module tb_if_id_stage_reg;

    localparam int CNT_W = 4;
    localparam logic [31:0] NOP_I = 32'h0000_0013;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_pred_taken;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_pred_taken;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    if_id_stage_reg #(.XLEN(32), .ILEN(32), .NOP(NOP_I), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_pred_taken(in_pred_taken),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_pred_taken(out_pred_taken),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } entry_t;

    entry_t      mq[$];
    int          m_cnt;
    logic [31:0] m_pc;
    int          passed = 0;
    int          total  = 0;
    int          popped_pc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt = 0;
        m_pc  = 32'h0;
    endtask

    task automatic check_all(input string tag);
        logic        ev;
        logic [31:0] ei;
        logic        ep;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].instr : NOP_I;
        ep = ev ? mq[0].pred : 1'b0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
        check({tag, ".out_pc"}, out_pc, m_pc);
        check({tag, ".out_instr"}, out_instr, ei);
        check({tag, ".out_pred"}, 32'(out_pred_taken), 32'(ep));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    // One clock cycle: drive at negedge, update the model at posedge, check 1 time unit later.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic st, input logic fl, input logic ordy);
        bit do_push, do_pop;
        entry_t e;
        @(negedge clk);
        in_valid      = iv;
        in_pc         = pc;
        in_instr      = $urandom;
        in_pred_taken = 1'($urandom_range(0, 1));
        stall         = st;
        flush         = fl;
        out_ready     = ordy;
        e.pc = pc; e.instr = in_instr; e.pred = in_pred_taken;
        do_push = iv && (mq.size() < 2);
        do_pop  = (mq.size() > 0) && ordy && !st;
        @(posedge clk);
        if ((mq.size() > 0) && !do_pop && (m_cnt < CNT_MAX)) m_cnt++;
        if (do_pop) popped_pc.push_back(int'(mq[0].pc));
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        if (mq.size() > 0) m_pc = mq[0].pc;
        #1;
        $display("[%0t] %s iv=%0b pc=%h st=%0b fl=%0b ordy=%0b -> ov=%0b opc=%h occ=%0d cnt=%0d",
                 $time, tag, iv, pc, st, fl, ordy, out_valid, out_pc, occupancy, stall_cnt);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0; in_pred_taken = 0;
        stall = 0; flush = 0; out_ready = 0;
        model_reset();

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        step("idle", 0, 32'h0, 0, 0, 1);
        check("idle.instr_nop", out_instr, NOP_I);

        // Streaming at full throughput
        for (int i = 0; i < 4; i++) begin
            step("stream", 1, 32'(i * 4), 0, 0, 1);
            check("stream.occ1", 32'(occupancy), 32'd1);
            check("stream.pc", out_pc, 32'(i * 4));
        end
        step("stream_drain", 0, 32'h0, 0, 0, 1);

        // Skid fill under stall, then drain
        step("skid_fill", 1, 32'h100, 1, 0, 1);
        step("skid_fill", 1, 32'h104, 1, 0, 1);
        check("skid.full_occ", 32'(occupancy), 32'd2);
        check("skid.head_pc", out_pc, 32'h100);
        step("skid_hold", 1, 32'h108, 1, 0, 1);
        step("skid_pop1", 0, 32'h0, 0, 0, 1);
        check("skid.pc104", out_pc, 32'h104);
        check("skid.ready_back", 32'(in_ready), 32'd1);
        step("skid_pop2", 0, 32'h0, 0, 0, 1);

        // Flush at FULL together with a push
        step("fl_fill", 1, 32'h180, 1, 0, 0);
        step("fl_fill", 1, 32'h184, 1, 0, 0);
        step("flush", 1, 32'h200, 0, 1, 0);
        check("flush.valid", 32'(out_valid), 32'd0);
        check("flush.nop", out_instr, NOP_I);
        check("flush.pc_not_200", 32'(out_pc != 32'h200), 32'd1);
        step("post_flush_push", 1, 32'h300, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle at FULL
        step("ar_fill", 1, 32'h400, 1, 0, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        in_valid = 0;

        // Stall counter saturation
        step("sat_load", 1, 32'h500, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat", 0, 32'h0, 1, 0, 1);
        check("sat.cnt15", 32'(stall_cnt), 32'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
